// File: rtl/bitonic_merge_seq_16.sv
// rtl/bitonic_merge_seq_16.sv - time-multiplexed 16-lane bitonic merger, 8 shared compare-swap units
module bitonic_merge_seq_16 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*DATA_WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [16*DATA_WIDTH-1:0]   out_data,
  output logic                       busy,
  output logic [1:0]                 stage,
  output logic [15:0]                jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Block buffer, one entry per lane
  logic [DATA_WIDTH-1:0] lanes      [16];
  logic [DATA_WIDTH-1:0] lanes_pass [16];

  // Per-unit lane selection for the current stride
  logic [3:0] lo_idx [8];
  logic [3:0] hi_idx [8];
  logic [3:0] stride;

  // Compare-swap unit outputs
  logic [DATA_WIDTH-1:0] cs_min [8];
  logic [DATA_WIDTH-1:0] cs_max [8];

  // Stride mux: map unit u to its lower lane j (bit log2(s) of j is zero) and upper lane j+s
  always_comb begin
    stride = 4'b1000 >> stage;
    for (int u = 0; u < 8; u++) begin
      logic [2:0] uu;
      uu = 3'(u);
      unique case (stage)
        2'd0:    lo_idx[u] = {1'b0, uu};
        2'd1:    lo_idx[u] = {uu[2], 1'b0, uu[1:0]};
        2'd2:    lo_idx[u] = {uu[2:1], 1'b0, uu[0]};
        default: lo_idx[u] = {uu, 1'b0};
      endcase
      hi_idx[u] = lo_idx[u] | stride;
    end
  end

  // The eight shared compare-swap units (unsigned; ties pass through unchanged)
  always_comb begin
    for (int u = 0; u < 8; u++) begin
      if (lanes[lo_idx[u]] > lanes[hi_idx[u]]) begin
        cs_min[u] = lanes[hi_idx[u]];
        cs_max[u] = lanes[lo_idx[u]];
      end else begin
        cs_min[u] = lanes[lo_idx[u]];
        cs_max[u] = lanes[hi_idx[u]];
      end
    end
  end

  // Scatter unit results back to lanes; the 8 pairs of a pass are disjoint and cover all lanes
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      lanes_pass[k] = lanes[k];
    end
    for (int u = 0; u < 8; u++) begin
      lanes_pass[lo_idx[u]] = cs_min[u];
      lanes_pass[hi_idx[u]] = cs_max[u];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; RUN lasts exactly four passes
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (stage == 2'd3) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load block, apply one pass per clock, count completed outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        lanes[k] <= '0;
      end
      stage     <= 2'd0;
      jobs_done <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 16; k++) begin
              lanes[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            stage <= 2'd0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < 16; k++) begin
            lanes[k] <= lanes_pass[k];
          end
          // Wraps 3 -> 0 on the final pass so stage reads 0 in DONE
          stage <= stage + 2'd1;
        end
        S_DONE: begin
          if (out_ready) begin
            jobs_done <= jobs_done + 16'd1;
          end
        end
        default: begin
          stage <= 2'd0;
        end
      endcase
    end
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    for (int k = 0; k < 16; k++) begin
      out_data[k*DATA_WIDTH +: DATA_WIDTH] = lanes[k];
    end
  end

endmodule
